regbank_ctrl: RTL and testbench
===============================

REGBANK_CTRL -- requirements
Module: regbank_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port cmd_valid, input, 1, command offered.
REQ-004 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-005 SHALL have port cmd_op, input, 2, operation: 00 single write, 01 single read, 10 block fill, 11 block read.
REQ-006 SHALL have port cmd_addr, input, 4, start register address.
REQ-007 SHALL have port cmd_len, input, 4, beat count minus one for block ops; ignored for single ops.
REQ-008 SHALL have port cmd_data, input, 8, write/fill data.
REQ-009 SHALL have port WR, output, 1, bank write strobe.
REQ-010 SHALL have port RD, output, 1, bank read enable.
REQ-011 SHALL have port address, output, 4, bank register address.
REQ-012 SHALL have port data_in, output, 8, bank write data.
REQ-013 SHALL have port Data_out, input, 8, bank read data, combinational from RD/address.
REQ-014 SHALL have port rsp_valid, output, 1, read response valid.
REQ-015 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid & rsp_ready at a rising edge.
REQ-016 SHALL have port rsp_data, output, 8, read data; rsp_addr, output, 4, its address; rsp_last, output, 1, final beat of command.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, WRITE, READ, HOLD; cmd_ready high only in IDLE.
REQ-019 SHALL on accept latch op, addr, len (0 for single ops), data; go to WRITE for ops 00/10, READ for 01/11.
REQ-020 SHALL in WRITE drive WR=1, RD=0, address=current addr, data_in=current data for exactly one cycle per beat; bank captures at that cycle's end edge.
REQ-021 SHALL in READ drive RD=1, WR=0, address=current addr; capture Data_out and addr into rsp_data/rsp_addr at that edge, set rsp_valid next cycle.
REQ-022 SHALL never assert WR and RD in the same cycle; both 0 in IDLE and HOLD, address held at last value.
REQ-023 SHALL after each beat increment address modulo 16 (15 wraps to 0) and decrement remaining count; last beat sets rsp_last (reads) and returns to IDLE.
REQ-024 SHALL, for reads, go to HOLD after capture and return to READ (next beat) or IDLE (last beat) only on the cycle rsp_valid & rsp_ready; rsp_valid clears on that handshake.
REQ-025 SHALL keep rsp_data/rsp_addr/rsp_last stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL throughput: writes one beat/cycle; reads one beat per two cycles with rsp_ready held high.
REQ-027 SHALL accept a new command in the cycle it returns to IDLE at the earliest (no back-to-back accept while busy).
REQ-028 SHALL treat cmd_len=15 as 16 beats covering every register exactly once.

Reset
REQ-029 SHALL on rst=1 immediately force IDLE, cmd_ready=1 after release, WR=0, RD=0, address=0, data_in=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, busy=0.
REQ-030 SHALL abort any in-progress command on reset mid-operation with no further bank strobes; already-written registers keep their values.

Configuration
REQ-031 SHALL with macro REGBANK_CTRL_FILL_INC_EN defined, drive block-fill beat i with data cmd_data+i modulo 256.
REQ-032 SHALL without REGBANK_CTRL_FILL_INC_EN, drive every block-fill beat with cmd_data unchanged; single writes unaffected either way.

Verification
REQ-033 SHALL: single write addr 5 data 0xA7, then single read addr 5 -> one WR pulse at address 5, rsp_data=0xA7, rsp_addr=5, rsp_last=1.
REQ-034 SHALL: block fill addr 14 len 3 data 0x10 -> WR on addresses 14,15,0,1 in 4 consecutive cycles; data 0x10,0x11,0x12,0x13 with macro, all 0x10 without.
REQ-035 SHALL: block read addr 0 len 15 with rsp_ready=1 -> 16 responses, addresses 0..15, rsp_last only on address 15, 32 busy cycles.
REQ-036 SHALL: block read len 2 with rsp_ready low for 5 cycles on beat 1 -> no RD during stall, response held stable, no beat lost or duplicated.
REQ-037 SHALL: rst asserted during beat 2 of a 4-beat fill -> WR drops asynchronously, addresses of beats 0-1 written, beats 2-3 untouched, all outputs at reset values.
REQ-038 SHALL: cmd_valid held high while busy -> cmd_ready=0, second command accepted only in the first IDLE cycle.

Source files
------------

// File: rtl/regbank_ctrl.sv
// regbank_ctrl: command front end for a 16 x 8-bit register bank.
//
// Accepts single and block write/read commands, drives the bank strobes
// one beat at a time and returns read data through a response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready
// are both high. A producer keeps valid and its payload stable until that
// edge; a consumer may move ready freely.
//   command  channel: cmd_valid (in)  / cmd_ready (out), payload cmd_*
//   response channel: rsp_valid (out) / rsp_ready (in),  payload rsp_*
//
// Build option:
//   REGBANK_CTRL_FILL_INC_EN - when defined, block-fill beat i writes
//   cmd_data + i (mod 256); otherwise every fill beat writes cmd_data.
//
// The FSM state is exported on dbg_state for checkers.

module regbank_ctrl (
    input  logic       clk,
    input  logic       rst,
    // command channel
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] cmd_data,
    // register bank port
    output logic       WR,
    output logic       RD,
    output logic [3:0] address,
    output logic [7:0] data_in,
    input  logic [7:0] Data_out,
    // response channel
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_addr,
    output logic       rsp_last,
    // status
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] addr_q;     // address of the beat being (or last) driven
    logic [3:0] rem_q;      // beats remaining after the current one
    logic [7:0] data_q;     // write data of the current beat
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic [3:0] rsp_addr_q;
    logic       rsp_last_q;

    logic       accept;
    logic       rsp_hs;
    logic       last_beat;
    logic       advance;

`ifdef REGBANK_CTRL_FILL_INC_EN
    logic       fill_q;     // current command is a block fill
`endif

    assign accept    = (state_q == IDLE) && cmd_valid;
    assign rsp_hs    = rsp_valid_q && rsp_ready;
    assign last_beat = (rem_q == 4'd0);

    // Step to the next beat: after a non-final write beat, or when a
    // non-final read response has been consumed. The address is only
    // bumped here so it rests on the last driven value while idle or holding.
    assign advance = ((state_q == WRITE) && !last_beat) ||
                     ((state_q == HOLD) && rsp_hs && !last_beat);

    // Next-state selection for the command FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_op[0] ? READ : WRITE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_hs) begin
                    state_d = last_beat ? IDLE : READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE at once, which drops WR/RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat datapath: latch the command on accept, then walk the address
    // (wrapping 15 -> 0) and count down the remaining beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 4'd0;
            rem_q  <= 4'd0;
            data_q <= 8'd0;
        end else if (accept) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_op[1] ? cmd_len : 4'd0;
            data_q <= cmd_data;
        end else if (advance) begin
            addr_q <= addr_q + 4'd1;
            rem_q  <= rem_q - 4'd1;
`ifdef REGBANK_CTRL_FILL_INC_EN
            if (fill_q) begin
                data_q <= data_q + 8'd1;
            end
`endif
        end
    end

`ifdef REGBANK_CTRL_FILL_INC_EN
    // Remember whether the accepted command is a block fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= (cmd_op == 2'b10);
        end
    end
`endif

    // Response register: capture bank data at the end of a READ cycle and
    // hold it untouched until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_addr_q  <= 4'd0;
            rsp_last_q  <= 1'b0;
        end else if (state_q == READ) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= Data_out;
            rsp_addr_q  <= addr_q;
            rsp_last_q  <= last_beat;
        end else if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign WR        = (state_q == WRITE);
    assign RD        = (state_q == READ);
    assign address   = addr_q;
    assign data_in   = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// tb_regbank_ctrl: directed bench for regbank_ctrl with a behavioural
// register bank, expected-write and expected-response queues, and a
// negedge monitor that pops and compares whenever the DUT presents a beat.

`timescale 1ns/1ps

module tb_regbank_ctrl;

`ifdef REGBANK_CTRL_FILL_INC_EN
    localparam bit FILL_INC = 1'b1;
`else
    localparam bit FILL_INC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_addr = 4'd0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       WR;
    logic       RD;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] Data_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [3:0] rsp_addr;
    logic       rsp_last;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;

    logic [11:0] exp_wr_q[$];   // {addr, data}
    logic [12:0] exp_rsp_q[$];  // {last, addr, data}
    logic [7:0]  ref_mem [16];  // intended bank contents
    logic [7:0]  bank_mem [16]; // behavioural bank

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    regbank_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .WR        (WR),
        .RD        (RD),
        .address   (address),
        .data_in   (data_in),
        .Data_out  (Data_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // behavioural register bank
    always @(posedge clk) begin
        if (WR) bank_mem[address] <= data_in;
    end
    assign Data_out = RD ? bank_mem[address] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [11:0] ew;
        logic [12:0] er;
        if (!rst) begin
            check("wr_rd_exclusive", {31'd0, WR & RD}, 32'd0);
            if (busy) busy_cnt++;
            if (WR) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected actual=addr %0d data 0x%0h required=no write", address, data_in);
                end else begin
                    ew = exp_wr_q.pop_front();
                    check("wr_beat", {20'd0, address, data_in}, {20'd0, ew});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=addr %0d data 0x%0h required=no response", rsp_addr, rsp_data);
                end else begin
                    er = exp_rsp_q.pop_front();
                    check("rsp_beat", {19'd0, rsp_last, rsp_addr, rsp_data}, {19'd0, er});
                end
            end
        end
    end

    // driver tasks (called at #1 after a rising edge)
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] len, input logic [7:0] d);
        bit accepted = 1'b0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !rsp_valid) idle = 1'b1;
        end
        check("wait_idle", {31'd0, idle}, 32'd1);
    endtask

    task automatic push_fill(input logic [3:0] a, input logic [7:0] d, input int nbeats);
        logic [3:0] ba;
        logic [7:0] bd;
        for (int i = 0; i < nbeats; i++) begin
            ba = a + 4'(i);
            bd = FILL_INC ? d + 8'(i) : d;
            exp_wr_q.push_back({ba, bd});
            ref_mem[ba] = bd;
        end
    endtask

    task automatic push_read(input logic [3:0] a, input logic [3:0] len);
        logic [3:0] ba;
        for (int i = 0; i <= int'(len); i++) begin
            ba = a + 4'(i);
            exp_rsp_q.push_back({(i == int'(len)), ba, ref_mem[ba]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_wr"},        {31'd0, WR},        32'd0);
        check({tag, "_rd"},        {31'd0, RD},        32'd0);
        check({tag, "_address"},   {28'd0, address},   32'd0);
        check({tag, "_data_in"},   {24'd0, data_in},   32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_data"},  {24'd0, rsp_data},  32'd0);
        check({tag, "_rsp_addr"},  {28'd0, rsp_addr},  32'd0);
        check({tag, "_rsp_last"},  {31'd0, rsp_last},  32'd0);
        check({tag, "_state"},     {30'd0, dbg_state}, 32'd0);
    endtask

    // directed test sequence
    initial begin
        int b0;
        int wait_cyc;
        bit found;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        // reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // single write addr 5 = 0xA7 (len ignored), then single read
        exp_wr_q.push_back({4'd5, 8'hA7});
        ref_mem[5] = 8'hA7;
        send_cmd(2'b00, 4'd5, 4'd9, 8'hA7);
        wait_idle();
        exp_rsp_q.push_back({1'b1, 4'd5, 8'hA7});
        send_cmd(2'b01, 4'd5, 4'd7, 8'h00);
        wait_idle();

        // block fill addr 14 len 3 data 0x10: wraps 14,15,0,1
        exp_wr_q.push_back({4'd14, 8'h10});
        exp_wr_q.push_back({4'd15, FILL_INC ? 8'h11 : 8'h10});
        exp_wr_q.push_back({4'd0,  FILL_INC ? 8'h12 : 8'h10});
        exp_wr_q.push_back({4'd1,  FILL_INC ? 8'h13 : 8'h10});
        send_cmd(2'b10, 4'd14, 4'd3, 8'h10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_wr_consecutive", {31'd0, WR}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("fill_wr_after_last", {31'd0, WR}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle();

        // full 16-beat fill then 16-beat read with rsp_ready high
        push_fill(4'd0, 8'h40, 16);
        send_cmd(2'b10, 4'd0, 4'd15, 8'h40);
        wait_idle();
        push_read(4'd0, 4'd15);
        b0 = busy_cnt;
        send_cmd(2'b11, 4'd0, 4'd15, 8'h00);
        wait_idle();
        check("block_read_busy_cycles", 32'(busy_cnt - b0), 32'd32);
        check("block_read_all_rsp", 32'(exp_rsp_q.size()), 32'd0);

        // block read addr 3 len 2 with a 5-cycle stall on beat 1
        push_read(4'd3, 4'd2);
        send_cmd(2'b11, 4'd3, 4'd2, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (rsp_valid && rsp_addr == 4'd4) begin
                found = 1'b1;
                rsp_ready = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("stall_beat1_seen", {31'd0, found}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_rd",     {31'd0, RD},        32'd0);
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rsp_addr",  {28'd0, rsp_addr},  32'd4);
            check("stall_rsp_data",  {24'd0, rsp_data},  {24'd0, FILL_INC ? 8'h44 : 8'h40});
            check("stall_rsp_last",  {31'd0, rsp_last},  32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("stall_all_rsp", 32'(exp_rsp_q.size()), 32'd0);

        // reset during beat 2 of a 4-beat fill at addr 8
        push_fill(4'd8, 8'hC0, 2);
        send_cmd(2'b10, 4'd8, 4'd3, 8'hC0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_beat2_wr",   {31'd0, WR},      32'd1);
        check("abort_beat2_addr", {28'd0, address}, 32'd10);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // 8,9 rewritten; 10,11 keep the earlier fill values
        check("abort_ref_r10", {24'd0, ref_mem[10]}, {24'd0, FILL_INC ? 8'h4A : 8'h40});
        for (int i = 8; i < 12; i++) begin
            push_read(4'(i), 4'd0);
            send_cmd(2'b01, 4'(i), 4'd0, 8'h00);
            wait_idle();
        end

        // cmd_valid held high while busy: second command in first IDLE cycle
        push_fill(4'd2, 8'h77, 3);
        exp_rsp_q.push_back({1'b1, 4'd2, 8'h77});
        send_cmd(2'b10, 4'd2, 4'd2, 8'h77);
        cmd_op    = 2'b01;
        cmd_addr  = 4'd2;
        cmd_len   = 4'd0;
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        wait_cyc  = 0;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                found = 1'b1;
            end else begin
                wait_cyc++;
                @(posedge clk);
                #1;
            end
        end
        check("b2b_ready_seen",   {31'd0, found}, 32'd1);
        check("b2b_busy_cycles",  32'(wait_cyc),  32'd3);
        check("b2b_idle_at_rdy",  {31'd0, busy},  32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("b2b_accepted_busy", {31'd0, busy},    32'd1);
        check("b2b_accepted_rd",   {31'd0, RD},      32'd1);
        check("b2b_accepted_addr", {28'd0, address}, 32'd2);
        wait_idle();

        // final report
        check("wr_queue_drained",  32'(exp_wr_q.size()),  32'd0);
        check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
